// File: rtl/digit_row_streamer.sv
// Frame scanner: walks page/digit/column, drives the 7seg column decoder and streams
// the returned pixel bytes out in SSD1306 horizontal-addressing order over valid/ready.
module digit_row_streamer #(
  parameter int DIGITS = 6,
  parameter int CHAR_W = 16,
  parameter int PAGES  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [7*DIGITS-1:0]   digits_segs,
  output logic [6:0]            seg_out,
  output logic [3:0]            index_x,
  output logic [1:0]            index_y,
  input  logic [7:0]            pixels_column,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PAGES  > 1) ? $clog2(PAGES)  : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [DW-1:0]       digit;
  logic [PW-1:0]       page;
  logic [7*DIGITS-1:0] snapshot;

  logic last_col, last_digit, last_page, at_final, load;

  assign last_col   = (col   == CW'(CHAR_W - 1));
  assign last_digit = (digit == DW'(DIGITS - 1));
  assign last_page  = (page  == PW'(PAGES - 1));
  assign at_final   = last_col && last_digit && last_page;
  assign load       = (state == RUN) && (!data_valid || data_ready);

  // Decoder inputs come straight from registers so they hold steady through stalls.
  assign index_x = 4'(col);
  assign index_y = 2'(page);

  always_comb begin
    seg_out = '0;
    for (int d = 0; d < DIGITS; d++)
      if (digit == DW'(d)) seg_out = snapshot[7*d +: 7];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      col        <= '0;
      digit      <= '0;
      page       <= '0;
      snapshot   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished frame.
          if (start && !done) begin
            snapshot <= digits_segs;
            col      <= '0;
            digit    <= '0;
            page     <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            data_out   <= pixels_column;
            data_valid <= 1'b1;
            frame_last <= at_final;
            if (at_final) begin
              state <= DRAIN;
            end else if (last_col) begin
              col <= '0;
              if (last_digit) begin
                digit <= '0;
                page  <= page + 1'b1;
              end else begin
                digit <= digit + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_row_streamer.sv
// Bench for digit_row_streamer: frame model as a byte queue built from nested page/digit/col
// loops, checked on every accepted byte, plus directed literal checks and a tiny-geometry instance.
module tb_digit_row_streamer;

  logic        clk = 1'b0;
  logic        resetn, start, drdy;
  logic [41:0] segs;
  logic [6:0]  seg_out;
  logic [3:0]  ix;
  logic [1:0]  iy;
  logic [7:0]  pix, dout;
  logic        dv, flast, busy, done;

  logic        startb;
  logic [6:0]  segsb, segob;
  logic [3:0]  ixb;
  logic [1:0]  iyb;
  logic [7:0]  pixb, doutb;
  logic        dvb, flastb, busyb, doneb;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, byte_cnt = 0, nz_cnt = 0, done_cnt = 0, acc_cyc = -10;
  logic [7:0] first_b, last_b, prev_d, exp_b;
  logic prev_l, prev_stall = 1'b0, rnd_rdy = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the 7seg column decoder: zero for a blank digit, otherwise a
  // position-dependent nonzero byte.
  function automatic logic [7:0] dec(input logic [6:0] s, input logic [3:0] x, input logic [1:0] y);
    return (s == 7'd0) ? 8'h00 : {1'b1, s ^ {x, y, 1'b0}};
  endfunction

  assign pix  = dec(seg_out, ix, iy);
  assign pixb = dec(segob, ixb, iyb);

  digit_row_streamer dut (
    .clk(clk), .resetn(resetn), .start(start), .digits_segs(segs),
    .seg_out(seg_out), .index_x(ix), .index_y(iy), .pixels_column(pix),
    .data_out(dout), .data_valid(dv), .data_ready(drdy), .frame_last(flast),
    .busy(busy), .done(done));

  digit_row_streamer #(.DIGITS(1), .CHAR_W(2), .PAGES(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(startb), .digits_segs(segsb),
    .seg_out(segob), .index_x(ixb), .index_y(iyb), .pixels_column(pixb),
    .data_out(doutb), .data_valid(dvb), .data_ready(1'b1), .frame_last(flastb),
    .busy(busyb), .done(doneb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build(input logic [41:0] s);
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < 6; d++)
        for (int c = 0; c < 16; c++)
          exp_q.push_back(dec(s[7*d +: 7], 4'(c), 2'(p)));
  endtask

  task automatic clear_stats();
    byte_cnt = 0; nz_cnt = 0; done_cnt = 0;
  endtask

  // Start a frame; also pins the start-to-first-valid latency.
  task automatic run_frame(input logic [41:0] s);
    clear_stats();
    segs = s;
    build(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_not_yet", 32'(dv), 32'd0);
    @(posedge clk); #1;
    chk("valid_first", 32'(dv), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (byte_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("byte_wait_timeout", 32'(byte_cnt >= target), 32'd1);
  endtask

  // Scoreboard: every accepted byte, every stall, every done pulse.
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (prev_stall)
        chk("hold", {22'd0, dv, flast, dout}, {22'd0, 1'b1, prev_l, prev_d});
      if (dv && drdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          chk("byte", {23'd0, flast, dout}, {23'd0, exp_q.size() == 0, exp_b});
        end
        if (byte_cnt == 0) first_b = dout;
        last_b = dout;
        byte_cnt++;
        if (dout != 8'h00) nz_cnt++;
        acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 32'(cyc - acc_cyc), 32'd1);
        chk("done_all_consumed", 32'(exp_q.size()), 32'd0);
      end
    end
    prev_stall = resetn && dv && !drdy;
    prev_d = dout;
    prev_l = flast;
  end

  initial begin
    drdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      drdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi, di, nb;
    logic [7:0] b0, b1;
    logic l0, l1;
    resetn = 1'b0; start = 1'b0; startb = 1'b0; segs = '0; segsb = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {11'd0, dv, flast, busy, done, dout, seg_out, ix, iy},
        {11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 4'd0, 2'd0});
    chk("rst_b_valid", 32'(dvb), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // all segments lit, ready held high
    run_frame({6{7'h7F}});
    wait_done(2000);
    chk("t1_bytes", 32'(byte_cnt), 32'd384);
    chk("t1_dones", 32'(done_cnt), 32'd1);
    chk("t1_first", 32'(first_b), 32'hFF);
    chk("t1_last", 32'(last_b), 32'h81);
    chk("t1_idle", {30'd0, busy, dv}, 32'd0);

    // random backpressure
    rnd_rdy = 1'b1;
    run_frame({6{7'h7F}});
    wait_done(4000);
    rnd_rdy = 1'b0;
    chk("t2_bytes", 32'(byte_cnt), 32'd384);
    chk("t2_dones", 32'(done_cnt), 32'd1);
    chk("t2_last", 32'(last_b), 32'h81);

    // only digit 0 lit; inputs changed mid-frame must not matter
    run_frame(42'h06);
    wait_bytes(50);
    segs = {6{7'h7F}};
    wait_done(2000);
    chk("t3_bytes", 32'(byte_cnt), 32'd384);
    chk("t3_nonzero", 32'(nz_cnt), 32'd64);
    chk("t3_first", 32'(first_b), 32'h86);

    // start during the frame and in the done cycle are ignored
    run_frame({6{7'h7F}});
    wait_bytes(10);
    segs = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (!done && nb < 2000) begin
      @(negedge clk);
      nb++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_restart", {30'd0, busy, dv}, 32'd0);
    chk("t4_bytes", 32'(byte_cnt), 32'd384);
    chk("t4_dones", 32'(done_cnt), 32'd1);

    // reset mid-frame aborts with no done
    run_frame({6{7'h7F}});
    wait_bytes(200);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("t5_valid_drop", 32'(dv), 32'd0);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    exp_q.delete();
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    run_frame(42'h0A5_C3F1_2B07 & {42{1'b1}});
    wait_done(2000);
    chk("t5_bytes", 32'(byte_cnt), 32'd384);
    chk("t5_dones", 32'(done_cnt), 32'd1);

    // tiny geometry: 1 digit, 2 columns, 1 page
    startb = 1'b1;
    @(posedge clk); #1;
    startb = 1'b0;
    nb = 0; bi = -1; di = -1; b0 = '0; b1 = '0; l0 = 1'b0; l1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dvb) begin
        if (nb == 0) begin b0 = doutb; l0 = flastb; end
        else begin b1 = doutb; l1 = flastb; end
        nb++;
        bi = i;
      end
      if (doneb) di = i;
    end
    chk("t6_bytes", 32'(nb), 32'd2);
    chk("t6_b0", {23'd0, l0, b0}, {23'd0, 1'b0, 8'hFF});
    chk("t6_b1", {23'd0, l1, b1}, {23'd0, 1'b1, 8'hF7});
    chk("t6_done", 32'(di - bi), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
